// File: rtl/permutation_core_pkg.sv
// Shared definitions for the Ascon permutation core: round counts, FSM
// encoding, linear-layer rotation amounts and small helper functions.
package permutation_core_pkg;

  // Legal round counts a of p^a.
  localparam logic [4:0] ROUNDS_A  = 5'd12;
  localparam logic [4:0] ROUNDS_B  = 5'd6;
  localparam logic [4:0] ROUNDS_B8 = 5'd8;

  // Linear layer: x_k ^= ROR(x_k, ROT_A[k]) ^ ROR(x_k, ROT_B[k]).
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Any round count other than 6, 8 or 12 runs as the full 12-round permutation.
  function automatic logic [4:0] eff_rounds(input logic [4:0] r);
    case (r)
      ROUNDS_A, ROUNDS_B, ROUNDS_B8: return r;
      default:                       return ROUNDS_A;
    endcase
  endfunction

  // Rotate a 64-bit lane right by n.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    logic [127:0] dbl;
    dbl = {x, x} >> n;
    return dbl[63:0];
  endfunction

endpackage

// File: rtl/permutation_core_round.sv
// One combinational Ascon round: constant addition on x2, bitsliced 5-bit
// S-box layer, then linear diffusion. ctr is the 1-based round index within
// a p^a run of length rounds.
module ascon_round
  import permutation_core_pkg::*;
(
  input  logic [319:0] state_i,
  input  logic [4:0]   ctr_i,
  input  logic [4:0]   rounds_i,
  output logic [319:0] state_o
);

  logic [3:0]  ridx;
  logic [7:0]  rc;
  logic [63:0] x [5];
  logic [63:0] s [5];
  logic [63:0] t [5];
  logic [63:0] l [5];

  // Constant addition, S-box and linear layer for a single round.
  always_comb begin
    // Absolute round number within the 12-round schedule: 12 - a + ctr - 1.
    ridx = 4'(5'd11 - eff_rounds(rounds_i) + ctr_i);
    rc   = {4'hF - ridx, ridx};

    for (int k = 0; k < 5; k++) begin
      x[k] = state_i[319 - 64*k -: 64];
    end
    x[2] = x[2] ^ {56'd0, rc};

    s[0] = x[0] ^ x[4];
    s[1] = x[1];
    s[2] = x[2] ^ x[1];
    s[3] = x[3];
    s[4] = x[4] ^ x[3];
    for (int k = 0; k < 5; k++) begin
      t[k] = ~s[k] & s[(k + 1) % 5];
    end
    for (int k = 0; k < 5; k++) begin
      s[k] = s[k] ^ t[(k + 1) % 5];
    end
    s[1] = s[1] ^ s[0];
    s[0] = s[0] ^ s[4];
    s[3] = s[3] ^ s[2];
    s[2] = ~s[2];

    for (int k = 0; k < 5; k++) begin
      l[k] = s[k] ^ ror64(s[k], ROT_A[k]) ^ ror64(s[k], ROT_B[k]);
    end
    state_o = {l[0], l[1], l[2], l[3], l[4]};
  end

endmodule

// File: rtl/permutation_core.sv
// Iterative Ascon permutation p^a (a in {6,8,12}). Latches a 320-bit state,
// applies UNROLL rounds per clock, then holds the result until consumed.
module permutation_core
  import permutation_core_pkg::*;
#(
  parameter int UNROLL = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   rounds_in,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [4:0]   ctr_q, ctr_d;
  logic [4:0]   rounds_q, rounds_d;
  logic [319:0] st_q, st_d;
  logic [319:0] rnd0;
  logic [319:0] rnd_last;
  logic [4:0]   last_idx;

  ascon_round u_round0 (
    .state_i  (st_q),
    .ctr_i    (ctr_q),
    .rounds_i (rounds_q),
    .state_o  (rnd0)
  );

  if (UNROLL == 1) begin : g_unroll1
    assign rnd_last = rnd0;
  end else if (UNROLL == 2) begin : g_unroll2
    logic [4:0] ctr_next;
    assign ctr_next = ctr_q + 5'd1;
    ascon_round u_round1 (
      .state_i  (rnd0),
      .ctr_i    (ctr_next),
      .rounds_i (rounds_q),
      .state_o  (rnd_last)
    );
  end else begin : g_unroll_bad
    $error("permutation_core: UNROLL must be 1 or 2");
    assign rnd_last = rnd0;
  end

  // Index of the last round applied this clock; the run ends when it reaches a.
  assign last_idx = ctr_q + 5'(UNROLL - 1);

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    rounds_d = rounds_q;
    st_d     = st_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d     = state_in;
          rounds_d = rounds_in;
          ctr_d    = 5'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        st_d = rnd_last;
        if (last_idx == eff_rounds(rounds_q)) begin
          state_d = DONE;
        end else begin
          ctr_d = ctr_q + 5'(UNROLL);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctr_q    <= 5'd0;
      rounds_q <= 5'd0;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      rounds_q <= rounds_d;
      st_q     <= st_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign state_out = st_q;

endmodule

// File: tb/tb_permutation_core.sv
// Directed bench for permutation_core: one UNROLL=1 and one UNROLL=2 instance
// checked against an independent reference model of the Ascon permutation.
module tb_permutation_core;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [4:0]   rounds_in [2];
  logic [319:0] state_in  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [319:0] state_out [2];
  logic         busy      [2];

  int n_chk;
  int n_err;
  logic [7:0] csts [16];
  int ncst;

  localparam logic [319:0] PAT_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                    64'h0000000000000000, 64'hffffffffffffffff,
                                    64'h8000000000000001};
  localparam logic [319:0] PAT_B = {64'h80400c0600000000, 64'h0011223344556677,
                                    64'h8899aabbccddeeff, 64'h0f0e0d0c0b0a0908,
                                    64'h0706050403020100};

  permutation_core #(.UNROLL(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .rounds_in (rounds_in[0]),
    .state_in  (state_in[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .state_out (state_out[0]),
    .busy      (busy[0])
  );

  permutation_core #(.UNROLL(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .rounds_in (rounds_in[1]),
    .state_in  (state_in[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .state_out (state_out[1]),
    .busy      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation written in the style of the C reference round.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 1; i <= a; i++) begin
      c  = 8'hF0 - 8'((12 - a + i - 1) * 15);
      x2 = x2 ^ {56'd0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = x0 ^ (~x1 & x2);
      t1 = x1 ^ (~x2 & x3);
      t2 = x2 ^ (~x3 & x4);
      t3 = x3 ^ (~x4 & x0);
      t4 = x4 ^ (~x0 & x1);
      t1 = t1 ^ t0; t0 = t0 ^ t4; t3 = t3 ^ t2; t2 = ~t2;
      x0 = t0 ^ rotr(t0, 19) ^ rotr(t0, 28);
      x1 = t1 ^ rotr(t1, 61) ^ rotr(t1, 39);
      x2 = t2 ^ rotr(t2, 1)  ^ rotr(t2, 6);
      x3 = t3 ^ rotr(t3, 10) ^ rotr(t3, 17);
      x4 = t4 ^ rotr(t4, 7)  ^ rotr(t4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // Accept a job on instance k and wait (bounded) for out_valid; records the
  // constant seen on the first round stage each RUN cycle of the UNROLL=1 core.
  task automatic start_job(input int k, input logic [319:0] st, input logic [4:0] a,
                           output int lat);
    int guard;
    guard = 0;
    while (!in_ready[k] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    state_in[k]  = st;
    rounds_in[k] = a;
    in_valid[k]  = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    ncst = 0;
    lat  = 0;
    while (!out_valid[k] && lat < 40) begin
      if (k == 0 && busy[0] && ncst < 16) begin
        csts[ncst] = u_dut1.u_round0.rc;
        ncst++;
      end
      @(posedge clk); #1; lat++;
    end
    check($sformatf("done_seen_u%0d", k + 1), 320'(out_valid[k]), 320'd1);
  endtask

  task automatic finish_job(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check($sformatf("in_ready_after_take_u%0d", k + 1), 320'(in_ready[k]), 320'd1);
    check($sformatf("out_valid_after_take_u%0d", k + 1), 320'(out_valid[k]), 320'd0);
  endtask

  task automatic check_consts(input int a);
    check($sformatf("rc_count_a%0d", a), 320'(ncst), 320'(a));
    for (int i = 1; i <= a; i++) begin
      check($sformatf("rc_a%0d_r%0d", a, i), 320'(csts[i - 1]),
            320'(8'hF0 - 8'((12 - a + i - 1) * 15)));
    end
  endtask

  task automatic run_case(input int k, input logic [319:0] st, input logic [4:0] a,
                          input int a_eff);
    int lat;
    start_job(k, st, a, lat);
    check($sformatf("latency_u%0d_a%0d", k + 1, a), 320'(lat), 320'(a_eff / (k + 1)));
    check($sformatf("result_u%0d_a%0d", k + 1, a), state_out[k], model_perm(st, a_eff));
    if (k == 0) check_consts(a_eff);
    finish_job(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [319:0] snap;
    int guard;
    n_chk = 0;
    n_err = 0;
    ncst  = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      rounds_in[k] = 5'd0;
      state_in[k]  = '0;
      out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_in_ready_u%0d", k + 1), 320'(in_ready[k]), 320'd1);
      check($sformatf("rst_out_valid_u%0d", k + 1), 320'(out_valid[k]), 320'd0);
      check($sformatf("rst_busy_u%0d", k + 1), 320'(busy[k]), 320'd0);
      check($sformatf("rst_state_out_u%0d", k + 1), state_out[k], 320'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // p^12, p^6, p^8 of the zero state on both unroll factors.
    for (int k = 0; k < 2; k++) begin
      run_case(k, 320'd0, 5'd12, 12);
      run_case(k, 320'd0, 5'd6, 6);
      run_case(k, 320'd0, 5'd8, 8);
      run_case(k, PAT_A, 5'd12, 12);
    end

    // Result held while the consumer stalls; input pulses ignored.
    start_job(0, PAT_B, 5'd8, lat);
    check("hold_latency", 320'(lat), 320'd8);
    snap = state_out[0];
    check("hold_result", snap, model_perm(PAT_B, 8));
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0];
      state_in[0] = PAT_A;
      rounds_in[0] = 5'd6;
      @(posedge clk); #1;
      check($sformatf("hold_out_valid_%0d", c), 320'(out_valid[0]), 320'd1);
      check($sformatf("hold_in_ready_%0d", c), 320'(in_ready[0]), 320'd0);
      check($sformatf("hold_state_%0d", c), state_out[0], snap);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("take_in_ready", 320'(in_ready[0]), 320'd1);
    check("take_no_accept", 320'(busy[0]), 320'd0);
    check("take_state_kept", state_out[0], snap);

    // Asynchronous reset in the middle of a run.
    state_in[0]  = PAT_A;
    rounds_in[0] = 5'd12;
    in_valid[0]  = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    guard = 0;
    while (u_dut1.ctr_q != 5'd5 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("mid_ctr_reached", 320'(u_dut1.ctr_q), 320'd5);
    check("mid_busy", 320'(busy[0]), 320'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 320'(busy[0]), 320'd0);
    check("arst_out_valid", 320'(out_valid[0]), 320'd0);
    check("arst_state_out", state_out[0], 320'd0);
    check("arst_in_ready", 320'(in_ready[0]), 320'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_case(0, PAT_A, 5'd12, 12);

    // Illegal round count behaves as 12 rounds.
    run_case(0, PAT_B, 5'd7, 12);
    run_case(1, PAT_B, 5'd7, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
